// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encoding for the MMIO UART transmitter.
package uart_pkg;
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_PARITY  = 3;
   localparam int ST_LVL_LSB = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;
endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head read; pointers carry a wrap bit so all slots are usable.
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic          do_push, do_pop;

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign level = wptr_q - rptr_q;
   assign dout  = mem_q[rptr_q[AW-1:0]];

   // A push into a full FIFO is legal when the head leaves on the same edge.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
      rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR registers, TX FIFO and baud-rate FSM.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd217
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   input  logic        wstrb,
   input  logic        rstrb,
   output logic [31:0] rdata,
   output logic        rbusy,
   output logic        wbusy,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   localparam uart_state_e AFTER_DATA = S_PARITY;
   localparam logic        PAR_BIT    = 1'b1;
`else
   localparam uart_state_e AFTER_DATA = S_STOP;
   localparam logic        PAR_BIT    = 1'b0;
`endif

   uart_state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d, snap_q, snap_d, div_q, div_d, div_eff;
   logic [7:0]  sh_q, sh_d, pend_byte_q, pend_byte_d;
   logic [2:0]  bit_q, bit_d;
   logic        par_q, par_d, tx_q, tx_d, pend_q, pend_d;
   logic [31:0] rdata_q, rdata_d, status;
   logic        pop, push, load, wr_tx, slot_ok;
   logic [7:0]  fifo_dout;
   logic        fifo_full, fifo_empty;
   logic [AW:0] fifo_level;
   logic [1:0]  sel;
   logic        unused_bits;

   assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], wmask[3:2]};

   uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pend_q ? pend_byte_q : wdata[7:0]),
      .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
   );

   assign sel     = addr[3:2];
   assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
   assign wr_tx   = wstrb && (sel == REG_TXDATA) && wmask[0];
   assign slot_ok = !fifo_full || pop;
   assign push    = (pend_q || wr_tx) && slot_ok;

   always_comb begin
      status = '0;
      status[ST_BUSY]                 = (state_q != S_IDLE);
      status[ST_FULL]                 = fifo_full;
      status[ST_EMPTY]                = fifo_empty;
      status[ST_PARITY]               = PAR_BIT;
      status[ST_LVL_LSB+7:ST_LVL_LSB] = 8'(fifo_level);
   end

   // Bus side: pending-byte stall, DIVISOR byte lanes, registered read data.
   always_comb begin
      pend_d      = pend_q ? !slot_ok : (wr_tx && !slot_ok);
      pend_byte_d = (wr_tx && !pend_q) ? wdata[7:0] : pend_byte_q;
      div_d       = div_q;
      if (wstrb && sel == REG_DIVISOR) begin
         if (wmask[0]) div_d[7:0]  = wdata[7:0];
         if (wmask[1]) div_d[15:8] = wdata[15:8];
      end
      rdata_d = rdata_q;
      if (rstrb) begin
         case (sel)
            REG_STATUS:  rdata_d = status;
            REG_DIVISOR: rdata_d = {16'd0, div_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   // tx is registered from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      snap_d  = snap_q;
      par_d   = par_q;
      tx_d    = 1'b1;
      load    = 1'b0;
      case (state_q)
         S_IDLE: load = !fifo_empty;
         S_START: begin
            tx_d = 1'b0;
            if (cnt_q == 16'd0) begin
               state_d = S_DATA;
               cnt_d   = snap_q - 16'd1;
               bit_d   = 3'd0;
            end else cnt_d = cnt_q - 16'd1;
         end
         S_DATA: begin
            tx_d = sh_q[0];
            if (cnt_q == 16'd0) begin
               sh_d  = sh_q >> 1;
               cnt_d = snap_q - 16'd1;
               if (bit_q == 3'd7) state_d = AFTER_DATA;
               else bit_d = bit_q + 3'd1;
            end else cnt_d = cnt_q - 16'd1;
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx_d = par_q;
            if (cnt_q == 16'd0) begin
               state_d = S_STOP;
               cnt_d   = snap_q - 16'd1;
            end else cnt_d = cnt_q - 16'd1;
         end
`endif
         S_STOP: begin
            if (cnt_q == 16'd0) begin
               if (!fifo_empty) load = 1'b1;
               else state_d = S_IDLE;
            end else cnt_d = cnt_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
      pop = load;
      if (load) begin
         sh_d    = fifo_dout;
         par_d   = ^fifo_dout;
         snap_d  = div_eff;
         cnt_d   = div_eff - 16'd1;
         state_d = S_START;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         bit_q       <= '0;
         snap_q      <= 16'd1;
         par_q       <= 1'b0;
         tx_q        <= 1'b1;
         pend_q      <= 1'b0;
         pend_byte_q <= '0;
         div_q       <= DIV_RESET;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         bit_q       <= bit_d;
         snap_q      <= snap_d;
         par_q       <= par_d;
         tx_q        <= tx_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
         div_q       <= div_d;
         rdata_q     <= rdata_d;
      end
   end

   assign tx    = tx_q;
   assign wbusy = pend_q;
   assign rdata = rdata_q;
   assign rbusy = 1'b0;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (default FIFO_DEPTH=8, DIV_RESET=217).
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int          FB        = PAR ? 11 : 10;
   localparam logic [31:0] STAT_IDLE = 32'h4 | (PAR ? 32'h8 : 32'h0);

   logic        clk = 0, rst_n = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic [3:0]  wmask = 0;
   logic        wstrb = 0, rstrb = 0;
   logic [31:0] rdata;
   logic        rbusy, wbusy, tx;
   int          cyc = 0;
   int          n_cmp = 0, n_bad = 0;

   uart_tx_mmio dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
      .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata), .rbusy(rbusy), .wbusy(wbusy), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Returns the edge index at which the write was sampled.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output int n);
      @(negedge clk);
      addr = a; wdata = d; wmask = m; wstrb = 1;
      @(negedge clk);
      wstrb = 0;
      n = cyc;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; rstrb = 1;
      @(negedge clk);
      rstrb = 0;
      d = rdata;
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (PAR && k == 9) return ^b;
      return 1'b1;
   endfunction

   // Samples each bit of one frame mid-bit; t0 is the first cycle tx shows the start bit.
   task automatic check_frame(input logic [7:0] b, input int t0, input int d, input string nm);
      for (int k = 0; k < FB; k++) begin
         wait_to(t0 + k*d + d/2);
         n_cmp++;
         if (tx !== exp_bit(b, k)) begin
            n_bad++;
            $display("FAIL %s bit%0d byte=%h: tx=%b expected %b", nm, k, b, tx, exp_bit(b, k));
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] r;
      @(negedge clk);
      n_cmp++; if (tx !== 1'b1)  begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_cmp++; if (wbusy !== 1'b0) begin n_bad++; $display("FAIL reset_wbusy: got %b expected 0", wbusy); end
      n_cmp++; if (rbusy !== 1'b0) begin n_bad++; $display("FAIL reset_rbusy: got %b expected 0", rbusy); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL reset_status: got %h expected %h", r, STAT_IDLE); end
      bus_read(32'h8, r);
      n_cmp++; if (r !== 32'd217) begin n_bad++; $display("FAIL reset_divisor: got %h expected %h", r, 32'd217); end
   endtask

   task automatic test_divisor_lanes;
      logic [31:0] r;
      int n;
      bus_write(32'h8, 32'hFFFF_1234, 4'b0001, n);
      bus_read(32'h8, r);
      n_cmp++; if (r !== 32'h0000_0034) begin n_bad++; $display("FAIL div_lane0: got %h expected 00000034", r); end
      bus_write(32'h8, 32'h0000_AB00, 4'b0010, n);
      bus_read(32'h8, r);
      n_cmp++; if (r !== 32'h0000_AB34) begin n_bad++; $display("FAIL div_lane1: got %h expected 0000ab34", r); end
      bus_write(32'h8, 32'hFFFF_0004, 4'b1111, n);
      bus_read(32'h8, r);
      n_cmp++; if (r !== 32'h0000_0004) begin n_bad++; $display("FAIL div_upper: got %h expected 00000004", r); end
   endtask

   task automatic test_single_frame;
      logic [31:0] r;
      int n;
      bus_write(32'h8, 32'd4, 4'b0011, n);
      bus_write(32'h0, 32'h55, 4'b0001, n);
      wait_to(n + 1);
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL latency_early: tx=%b expected 1 at N+1", tx); end
      wait_to(n + 2);
      n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL latency_start: tx=%b expected 0 at N+2", tx); end
      check_frame(8'h55, n + 2, 4, "frame55");
      wait_to(n + 1 + FB*4);
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE || tx !== 1'b1) begin
         n_bad++; $display("FAIL frame55_idle: status=%h tx=%b expected %h/1", r, tx, STAT_IDLE);
      end
   endtask

   task automatic test_div_zero;
      logic [31:0] r;
      int n;
      bus_write(32'h8, 32'd0, 4'b0011, n);
      bus_write(32'h0, 32'hA5, 4'b0001, n);
      check_frame(8'hA5, n + 2, 1, "div0");
      wait_to(n + 2 + FB);
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL div0_idle: status=%h expected %h", r, STAT_IDLE); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      logic [7:0]  bytes [10];
      int n, e1, t0;
      for (int i = 0; i < 10; i++) bytes[i] = 8'(i*8'h13 + 8'h01);
      bus_write(32'h8, 32'd100, 4'b0011, n);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         addr = 32'h0; wdata = {24'h0, bytes[i]}; wmask = 4'b0001; wstrb = 1;
      end
      @(negedge clk);
      wstrb = 0;
      e1 = cyc - 9;
      t0 = e1 + 2;
      n_cmp++; if (wbusy !== 1'b1) begin n_bad++; $display("FAIL b2b_wbusy_high: got %b expected 1", wbusy); end
      bus_read(32'h4, r);
      n_cmp++; if (r !== (STAT_IDLE ^ 32'h0000_0807)) begin
         n_bad++; $display("FAIL b2b_status_full: got %h expected %h", r, STAT_IDLE ^ 32'h0000_0807);
      end
      check_frame(bytes[0], t0, 100, "b2b");
      wait_to(t0 + FB*100 - 2);
      n_cmp++; if (wbusy !== 1'b1) begin n_bad++; $display("FAIL b2b_wbusy_hold: got %b expected 1", wbusy); end
      wait_to(t0 + FB*100 - 1);
      n_cmp++; if (wbusy !== 1'b0) begin n_bad++; $display("FAIL b2b_wbusy_drop: got %b expected 0", wbusy); end
      for (int f = 1; f < 10; f++) check_frame(bytes[f], t0 + f*FB*100, 100, "b2b");
      wait_to(t0 + 10*FB*100 + 2);
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL b2b_done: status=%h expected %h", r, STAT_IDLE); end
   endtask

   task automatic test_ignored_writes;
      logic [31:0] r;
      int n;
      bus_write(32'h0, 32'hFF, 4'b1110, n);
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL mask_nopush: status=%h expected %h", r, STAT_IDLE); end
      bus_read(32'hC, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL read_reg3: got %h expected 0", r); end
      bus_read(32'h4, r);
      bus_read(32'h0, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL read_txdata: got %h expected 0", r); end
      bus_write(32'h4, 32'hFFFF_FFFF, 4'b1111, n);
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL status_ro: got %h expected %h", r, STAT_IDLE); end
   endtask

   task automatic test_parity;
      logic [31:0] r;
      int n;
      bus_write(32'h8, 32'd2, 4'b0011, n);
      bus_write(32'h0, 32'h07, 4'b0001, n);
      check_frame(8'h07, n + 2, 2, "par07");
      wait_to(n + 1 + 22);
      bus_read(32'h4, r);
      n_cmp++; if (r !== 32'h0000_000C) begin n_bad++; $display("FAIL par_status: got %h expected 0000000c", r); end
      bus_write(32'h0, 32'h03, 4'b0001, n);
      check_frame(8'h03, n + 2, 2, "par03");
      wait_to(n + 1 + 22);
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] r;
      int n, n0, lows;
      bus_write(32'h8, 32'd4, 4'b0011, n0);
      bus_write(32'h0, 32'h00, 4'b0001, n0);
      for (int i = 0; i < 3; i++) bus_write(32'h0, 32'h00, 4'b0001, n);
      wait_to(n0 + 2 + 4*4 + 1);
      n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rst_pre_tx: got %b expected 0", tx); end
      rst_n = 0;
      #1;
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      bus_read(32'h4, r);
      n_cmp++; if (r !== STAT_IDLE) begin n_bad++; $display("FAIL rst_status: got %h expected %h", r, STAT_IDLE); end
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL rst_quiet: %0d low cycles, expected 0", lows); end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1;
      test_reset;
      test_divisor_lanes;
      test_single_frame;
      test_div_zero;
      test_back_to_back;
      test_ignored_writes;
      if (PAR) test_parity;
      test_reset_mid_frame;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the rv32i data bus, a peer of the data RAM on the mem_d_* strobe/busy interface. CPU stores bytes into an internal FIFO. A baud-rate FSM serialises them onto a single tx pin, giving the soft core a console beyond the LED counter. Control-register set: TXDATA, STATUS, DIVISOR.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
DIV_RESET, 217, reset value of DIVISOR, in clk cycles per bit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address; only addr[3:2] decoded
wdata  input  32  write data
wmask  input  4  byte write enables
wstrb  input  1  one-cycle write strobe
rstrb  input  1  one-cycle read strobe
rdata  output  32  read data, registered
rbusy  output  1  read busy; tied 0, since reads complete in 1 cycle
wbusy  output  1  write stalled while TXDATA write waits for FIFO space
tx  output  1  serial line; idle high

Behaviour:
- Reset (async, rst_n=0): tx=1, rdata=0, wbusy=0, FIFO empty, FSM=IDLE, DIVISOR=DIV_RESET.
- Register map, selected by addr[3:2]:
  - 0 TXDATA (W): push wdata[7:0] if wmask[0]; reads return 0.
  - 1 STATUS (R): bit0 fsm_busy, bit1 fifo_full, bit2 fifo_empty, bits[15:8] fifo_level; other bits 0; writes ignored.
  - 2 DIVISOR (RW): bits[15:0], written per byte lane wmask[1:0]; upper bits read 0.
  - 3: reads 0, writes ignored.
- Reads: rdata updates the cycle after rstrb and holds until the next rstrb.
- Write handshake:
  - TXDATA wstrb with FIFO not full: push in the same edge; wbusy stays 0.
  - FIFO full: latch byte, raise wbusy next cycle, hold wbusy until the first cycle a slot frees.
  - That cycle: latched byte is pushed, wbusy drops the following cycle.
  - Further wstrb while wbusy=1 is a protocol violation; behaviour undefined.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the pending byte pushes that cycle.
- FSM states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START.
  - IDLE: tx=1; if FIFO non-empty, pop and latch shift register plus divisor snapshot, go to START.
  - Each bit lasts max(DIVISOR,1) cycles, counted by a 16-bit down-counter reloaded per bit.
  - STOP: tx=1 for one bit time; then, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else IDLE.
- Latency: byte written at edge N gives tx=0 (start bit) from edge N+2 when FSM is IDLE.
- DIVISOR writes mid-frame take effect at the next frame's start. DIVISOR=0 behaves as 1.
- fsm_busy=1 in any state other than IDLE.
- FIFO pointers carry one extra wrap bit; full/empty are derived from pointer compare, with no wasted slot.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state between DATA and STOP emits even parity (XOR of the 8 data bits); frame is 11 bits.
- Undefined: no PARITY state; frame is 10 bits.
- STATUS bit3 reads 1 when compiled in, 0 otherwise.

Decomposition:
- Package uart_pkg:
  - register offsets (REG_TXDATA=0, REG_STATUS=1, REG_DIVISOR=2)
  - STATUS bit indices
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
- One sub-module, uart_fifo:
  - synchronous FIFO, parameterised width/depth
  - ports clk, rst_n, push, pop, din, dout, full, empty, level
  - dout is the head entry, combinational read.

Test Plan:
- Reset then read STATUS and DIVISOR -> tx=1, STATUS=0x00000004, DIVISOR=217.
- Write DIVISOR=4, write TXDATA=0x55 at edge N -> tx low from N+2; bit sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; tx=1 and fsm_busy=0 after 40 cycles.
- DIVISOR=100, ten back-to-back TXDATA writes (FIFO_DEPTH=8):
  - 1st popped, 2nd-9th fill FIFO (STATUS fifo_full=1, level=8);
  - 10th raises wbusy until the 1st frame's STOP ends, then drops;
  - all 10 bytes appear on tx in order with no idle gap.
- Write TXDATA with wmask=4'b1110 -> no push (fifo_empty stays 1); read addr 0xC -> rdata=0; write addr 0x4 -> STATUS unchanged.
- Assert rst_n=0 mid-DATA of a frame with 3 bytes queued -> tx=1 immediately (async), STATUS=0x4 after release, no further frame bits.
- With UART_TX_PARITY_EN, DIVISOR=2, send 0x07 -> parity bit=1, frame 22 cycles; send 0x03 -> parity bit=0; STATUS bit3=1.
